// File: rtl/enc_frame_builder.sv
// enc_frame_builder: store-and-forward framer feeding an 8b/10b encoder.
// Payload bytes are buffered until a packet is complete, then emitted as one
// contiguous symbol stream: commas, SOP, payload, CRC-8, EOP.
module enc_frame_builder #(
  parameter int DEPTH     = 64,
  parameter int COMMA_CNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pushin,
  input  logic       startin,
  input  logic       lastin,
  input  logic [7:0] datain,
  output logic       fullout,
  output logic       pushout,
  output logic       startout,
  output logic [8:0] dataout,
  output logic       errout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (COMMA_CNT > 1) ? $clog2(COMMA_CNT) : 1;
  localparam logic [AW:0]   PTR_ONE   = 1;
  localparam logic [AW:0]   FULL_CNT  = DEPTH;
  localparam logic [CW-1:0] COMMA_TOP = CW'(COMMA_CNT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COMMA = 3'd1;
  localparam logic [2:0] S_SOP   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;
  localparam logic [2:0] S_EOP   = 3'd5;

  localparam logic [8:0] SYM_COMMA = 9'h1BC;
  localparam logic [8:0] SYM_SOP   = 9'h1FB;
  localparam logic [8:0] SYM_EOP   = 9'h1FD;

  // Entry = {last, byte}; pointers carry one extra wrap bit.
  logic [8:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, pkt_start_ptr;
  logic [AW:0]   wr_ptr_nx, rd_ptr_nx, start_nx, wr_addr;
  logic [AW:0]   pkt_cnt;
  logic          in_pkt, in_pkt_nx;
  logic          wr_en, err_set, last_acc;
  logic [2:0]    state;
  logic [CW-1:0] comma_cnt;
  logic [7:0]    crc;
  logic [8:0]    rd_word;

  // One bit-serial CRC-8 step per payload bit, poly 0x07, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'h07;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  assign rd_word   = mem[rd_ptr[AW-1:0]];
  assign rd_ptr_nx = (state == S_DATA) ? rd_ptr + PTR_ONE : rd_ptr;

  // Input-side decision: accept, drop, or rewind a partial packet.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_en     = 1'b0;
    wr_addr   = wr_ptr;
    wr_ptr_nx = wr_ptr;
    start_nx  = pkt_start_ptr;
    in_pkt_nx = in_pkt;
    err_set   = 1'b0;
    last_acc  = 1'b0;
    if (pushin) begin
      if (fullout) begin
        // Overflow: only the partial packet is discarded; complete ones stay.
        err_set   = 1'b1;
        in_pkt_nx = 1'b0;
        if (in_pkt) wr_ptr_nx = pkt_start_ptr;
      end else if (!startin && !in_pkt) begin
        err_set = 1'b1;
      end else begin
        if (startin) begin
          if (in_pkt) begin
            err_set = 1'b1;
            wr_addr = pkt_start_ptr;
          end
          start_nx = wr_addr;
        end
        wr_en     = 1'b1;
        wr_ptr_nx = wr_addr + PTR_ONE;
        in_pkt_nx = !lastin;
        last_acc  = lastin;
      end
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; pointers alone define which entries are valid.
    if (wr_en) mem[wr_addr[AW-1:0]] <= {lastin, datain};
  end

  // Write pointer, packet tracking, full flag and sticky error.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      wr_ptr        <= '0;
      pkt_start_ptr <= '0;
      in_pkt        <= 1'b0;
      errout        <= 1'b0;
      fullout       <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      wr_ptr        <= wr_ptr_nx;
      pkt_start_ptr <= start_nx;
      in_pkt        <= in_pkt_nx;
      fullout       <= (wr_ptr_nx - rd_ptr_nx) == FULL_CNT;
      if (err_set) errout <= 1'b1;
      case ({last_acc, state == S_EOP})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Frame sequencer: state names the symbol to be registered next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      comma_cnt <= '0;
      crc       <= 8'h00;
      rd_ptr    <= '0;
    end else begin
      rd_ptr <= rd_ptr_nx;
      case (state)
        S_IDLE: if (pkt_cnt != '0) begin
          state     <= S_COMMA;
          comma_cnt <= COMMA_TOP;
        end
        S_COMMA: if (comma_cnt == '0) state <= S_SOP;
                 else comma_cnt <= comma_cnt - 1'b1;
        S_SOP: begin
          crc   <= 8'h00;
          state <= S_DATA;
        end
        S_DATA: begin
          crc <= crc8_byte(crc, rd_word[7:0]);
          if (rd_word[8]) state <= S_CRC;
        end
        S_CRC:   state <= S_EOP;
        S_EOP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered symbol outputs, one cycle behind the sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pushout  <= 1'b0;
      startout <= 1'b0;
      dataout  <= 9'h000;
    end else begin
      pushout  <= (state != S_IDLE);
      startout <= (state == S_SOP);
      case (state)
        S_COMMA: dataout <= SYM_COMMA;
        S_SOP:   dataout <= SYM_SOP;
        S_DATA:  dataout <= {1'b0, rd_word[7:0]};
        S_CRC:   dataout <= {1'b0, crc};
        S_EOP:   dataout <= SYM_EOP;
        default: dataout <= dataout;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_frame_builder.sv
// Testbench for enc_frame_builder: directed scenarios with random payloads,
// checked against a frame-level reference model and a symbol monitor.
module tb_enc_frame_builder;

  localparam int DEPTH     = 64;
  localparam int COMMA_CNT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pushin = 1'b0, startin = 1'b0, lastin = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       fullout, pushout, startout, errout;
  logic [8:0] dataout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct { int cyc; bit st; logic [8:0] d; } obs_t;
  typedef struct { logic [8:0] d; bit st; bit first; } exp_t;
  obs_t obs_q[$];
  exp_t exp_q[$];

  enc_frame_builder #(.DEPTH(DEPTH), .COMMA_CNT(COMMA_CNT)) dut (
    .clk(clk), .reset(reset), .pushin(pushin), .startin(startin),
    .lastin(lastin), .datain(datain), .fullout(fullout), .pushout(pushout),
    .startout(startout), .dataout(dataout), .errout(errout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Symbol monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (pushout === 1'b1) obs_q.push_back('{cyc: cyc, st: startout, d: dataout});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference CRC: remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [7:0] p[$]);
    bit bits[$];
    logic [8:0] rem = 9'h000;
    foreach (p[i]) for (int b = 7; b >= 0; b--) bits.push_back(p[i][b]);
    repeat (8) bits.push_back(1'b0);
    foreach (bits[i]) begin
      rem = {rem[7:0], bits[i]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  task automatic add_frame(input logic [7:0] p[$]);
    for (int i = 0; i < COMMA_CNT; i++) exp_q.push_back('{d: 9'h1BC, st: 1'b0, first: (i == 0)});
    exp_q.push_back('{d: 9'h1FB, st: 1'b1, first: 1'b0});
    foreach (p[i]) exp_q.push_back('{d: {1'b0, p[i]}, st: 1'b0, first: 1'b0});
    exp_q.push_back('{d: {1'b0, ref_crc(p)}, st: 1'b0, first: 1'b0});
    exp_q.push_back('{d: 9'h1FD, st: 1'b0, first: 1'b0});
  endtask

  task automatic push_byte(input logic [7:0] d, input bit st, input bit ls);
    @(negedge clk);
    pushin = 1'b1; startin = st; lastin = ls; datain = d;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    pushin = 1'b0; startin = 1'b0; lastin = 1'b0;
  endtask

  task automatic push_pkt(input logic [7:0] p[$]);
    foreach (p[i]) push_byte(p[i], i == 0, i == p.size() - 1);
  endtask

  task automatic rand_pkt(input int len, output logic [7:0] p[$]);
    p.delete();
    repeat (len) p.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pushin = 1'b0; startin = 1'b0; lastin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_obs(input string tag);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (12) @(posedge clk);
    check({tag, " in_time"}, n < 3000, 1);
  endtask

  task automatic compare_all(input string tag);
    check({tag, " count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s sym%0d data", tag, i), obs_q[i].d, exp_q[i].d);
      check($sformatf("%s sym%0d start", tag, i), obs_q[i].st, exp_q[i].st);
      if (!exp_q[i].first && i > 0)
        check($sformatf("%s sym%0d contiguous", tag, i), obs_q[i].cyc - obs_q[i-1].cyc, 1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] p[$], q[$];
    int e, n, len1, idx;

    // 1) reset state, single-byte packet and first-comma latency
    do_reset();
    check("rst pushout", pushout, 0);
    check("rst startout", startout, 0);
    check("rst dataout", dataout, 0);
    check("rst errout", errout, 0);
    check("rst fullout", fullout, 0);
    p = '{8'h01};
    push_pkt(p);
    e = acc_cyc;
    add_frame(p);
    wait_obs("t1");
    if (obs_q.size() > 0) check("t1 latency", obs_q[0].cyc - e, 2);
    if (obs_q.size() > 4) check("t1 crc const", obs_q[4].d, 9'h007);
    compare_all("t1");

    // 2) check-string packet
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    push_pkt(p);
    add_frame(p);
    wait_obs("t2");
    check("t2 len", obs_q.size(), 14);
    if (obs_q.size() > 12) check("t2 crc const", obs_q[12].d, 9'h0F4);
    compare_all("t2");

    // 3) two packets back-to-back: frames one IDLE cycle apart
    len1 = $urandom_range(8, 4);
    rand_pkt(len1, p);
    rand_pkt($urandom_range(len1, 1), q);
    push_pkt(p);
    push_pkt(q);
    add_frame(p);
    add_frame(q);
    wait_obs("t3");
    idx = COMMA_CNT + 3 + len1;
    if (obs_q.size() > idx) check("t3 gap", obs_q[idx].cyc - obs_q[idx-1].cyc, 2);
    check("t3 pkt_cnt", dut.pkt_cnt, 0);
    compare_all("t3");

    // 4) oversize packet: full at DEPTH, dropped, next packet clean
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), i == 0, 1'b0);
    check("t4 full", fullout, 1);
    check("t4 err before", errout, 0);
    push_byte(8'hAA, 1'b0, 1'b1);
    check("t4 err", errout, 1);
    check("t4 full cleared", fullout, 0);
    repeat (20) @(posedge clk);
    check("t4 no frame", obs_q.size(), 0);
    rand_pkt(3, p);
    push_pkt(p);
    add_frame(p);
    wait_obs("t4");
    compare_all("t4");

    // 5) stray byte while idle, then restart mid-packet
    do_reset();
    push_byte(8'h55, 1'b0, 1'b0);
    check("t5 stray err", errout, 1);
    repeat (10) @(posedge clk);
    check("t5 stray no frame", obs_q.size(), 0);
    push_byte(8'h11, 1'b1, 1'b0);
    push_byte(8'h22, 1'b0, 1'b0);
    rand_pkt(3, p);
    push_pkt(p);
    add_frame(p);
    wait_obs("t5");
    check("t5 err sticky", errout, 1);
    compare_all("t5");

    // 6) reset during DATA
    rand_pkt(10, p);
    push_pkt(p);
    n = 0;
    while (obs_q.size() < COMMA_CNT + 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("t6 reached data", n < 200, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6 pushout", pushout, 0);
    check("t6 startout", startout, 0);
    check("t6 dataout", dataout, 0);
    check("t6 errout", errout, 0);
    check("t6 fullout", fullout, 0);
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    repeat (30) @(posedge clk);
    check("t6 silent", obs_q.size(), 0);
    rand_pkt(4, p);
    push_pkt(p);
    add_frame(p);
    wait_obs("t6");
    compare_all("t6");

    // 7) random packets with random gaps
    for (int k = 0; k < 4; k++) begin
      rand_pkt($urandom_range(12, 1), p);
      push_pkt(p);
      add_frame(p);
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end
    wait_obs("t7");
    compare_all("t7");
    check("t7 errout", errout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
